// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared tags, geometry and FSM encoding for the tile scheduler
package vga_pkg;

  localparam logic [15:0] TAG_CELL_MIN = 16'h0001;
  localparam logic [15:0] TAG_CELL_MAX = 16'h0009;
  localparam logic [15:0] TAG_STATUS   = 16'h000A;
  localparam logic [15:0] TAG_CLR_ERR  = 16'h000B;

  localparam int NUM_CELLS = 9;
  localparam int CELL_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic is_cell_tag(input logic [15:0] tag);
    return (tag >= TAG_CELL_MIN) && (tag <= TAG_CELL_MAX);
  endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// rtl/vga_cmd_fifo.sv - synchronous command FIFO with registered full/empty flags
module vga_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   level_nxt;

  // A push against a full FIFO is refused even when a pop frees a slot this cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LVL_ONE;
    end else if (!do_push && do_pop) begin
      level_nxt = level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/vga_tile_sched.sv
// rtl/vga_tile_sched.sv - queues CPU tile writes and applies them only during vblank
module vga_tile_sched
  import vga_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_we,
  input  logic [31:0]                 cpu_wdata,
  input  logic                        vblank,
  output logic                        cpu_full,
  output logic [AW:0]                 fifo_level,
  output logic [NUM_CELLS*CELL_W-1:0] tile_idx_flat,
  output logic [31:0]                 status_word,
  output logic                        apply_pulse,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  logic [15:0]       tag;
  logic              cell_cmd;
  logic              status_cmd;
  logic              clr_cmd;
  logic              illegal_cmd;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [31:0]       head;
  logic [3:0]        head_cell;
  logic [CELL_W-1:0] head_payload;
  logic              unused_head;
  state_t            state;
  state_t            state_nxt;
  logic [CELL_W-1:0] tiles [NUM_CELLS];

  assign tag          = cpu_wdata[31:16];
  assign cell_cmd     = cpu_we && is_cell_tag(tag);
  assign status_cmd   = cpu_we && (tag == TAG_STATUS);
  assign clr_cmd      = cpu_we && (tag == TAG_CLR_ERR);
  assign illegal_cmd  = cpu_we && !is_cell_tag(tag) && (tag != TAG_STATUS) && (tag != TAG_CLR_ERR);
  assign push         = cell_cmd && !cpu_full;
  assign pop          = (state == DRAIN) && vblank && !fifo_empty;

  assign head_cell    = head[19:16];
  assign head_payload = head[15:0];
  assign unused_head  = ^head[31:20];

  vga_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cpu_wdata),
    .pop       (pop),
    .pop_data  (head),
    .full      (cpu_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leaving blanking with work still queued parks in WAIT for the next interval.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = vblank ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (vblank) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!vblank) begin
          state_nxt = fifo_empty ? IDLE : WAIT;
        end else if (fifo_empty) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CELLS; k++) begin
        tiles[k] <= '0;
      end
    end else if (pop) begin
      for (int k = 0; k < NUM_CELLS; k++) begin
        if (head_cell == 4'(k + 1)) begin
          tiles[k] <= head_payload;
        end
      end
    end
  end

  always_comb begin
    tile_idx_flat = '0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      tile_idx_flat[k*CELL_W +: CELL_W] = tiles[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_word <= '0;
      apply_pulse <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      apply_pulse <= pop;
      if (status_cmd) begin
        status_word <= cpu_wdata;
      end
      // Illegal tags only count; they never mark overflow even with the FIFO full.
      if (clr_cmd) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (cell_cmd && cpu_full) begin
          overflow <= 1'b1;
        end
        if (illegal_cmd && (drop_cnt != 8'hFF)) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule
